pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
- REQ-001 SHALL have parameter N, default 8: operand and result width in bits, N>=2.
- REQ-002 SHALL have parameter STAGES, default 2: number of carry-chain segments and pipeline registers, STAGES>=1, N%STAGES==0.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port in_valid, input, 1: operands present this cycle.
- REQ-006 SHALL have port in_ready, output, 1: pipeline accepts operands this cycle.
- REQ-007 SHALL have ports A and B, input, N each: operands.
- REQ-008 SHALL have port cin, input, 1: carry-in, used in add mode only.
- REQ-009 SHALL have port sub, input, 1: 0 selects add, 1 selects subtract.
- REQ-010 SHALL have port out_valid, output, 1: result present.
- REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
- REQ-012 SHALL have port S, output, N: result.
- REQ-013 SHALL have port carry, output, 1: raw carry-out of the MSB.
- REQ-014 SHALL have port ovf, output, 1: signed (two's-complement) overflow.

Function
- REQ-015 SHALL compute, in add mode, {carry,S} = A + B + cin.
- REQ-016 SHALL compute, in subtract mode, {carry,S} = A + ~B + 1, with cin ignored; carry=1 means no borrow.
- REQ-017 SHALL split the chain into STAGES segments of N/STAGES bits, LSB segment first; segment k is computed in pipeline stage k from the registered carry of stage k-1.
- REQ-018 SHALL carry the not-yet-consumed operand slices, the mode and the partial sums forward with each stage's valid bit.
- REQ-019 SHALL use a global advance enable: en = !out_valid | out_ready; in_ready = en; every stage register loads only when en=1.
- REQ-020 SHALL accept a transfer when in_valid & in_ready; the result is presented with out_valid=1 exactly STAGES cycles later, provided there is no stall.
- REQ-021 SHALL sustain one result per cycle with out_ready held 1, STAGES results in flight, and no bubbles inserted.
- REQ-022 SHALL hold S, carry, ovf and out_valid stable while out_valid=1 and out_ready=0; no result is lost or duplicated.
- REQ-023 SHALL load a bubble (valid=0) into stage 1 when en=1 and in_valid=0.
- REQ-024 SHALL set ovf = (MSB of A) == (MSB of effective B) and (MSB of S) != (MSB of A), where effective B is ~B in subtract mode; ovf is computed from the unsaturated result.
- REQ-025 SHALL, when out_valid=0, have S, carry and ovf hold their last values; their values are don't-care for the consumer.

Reset
- REQ-026 SHALL, while rst_n=0, clear all stage valid bits, data and carry registers, so out_valid=0, S=0, carry=0, ovf=0, in_ready=1.
- REQ-027 SHALL, when reset is asserted mid-operation, discard all in-flight operations with no partial result emitted.
- REQ-028 SHALL accept a transfer on the first rising edge after rst_n deasserts.

Configuration
- REQ-029 SHALL, with macro PIPELINED_ADDER_SAT_EN defined, apply unsigned saturation at the output: add with carry=1 gives S=all ones; subtract with carry=0 (borrow) gives S=0; carry and ovf still report raw values.
- REQ-030 SHALL, without PIPELINED_ADDER_SAT_EN, have S wrap modulo 2^N; ports are identical in both builds.

Verification (N=8, STAGES=2)
- REQ-031 SHALL check: A=0xFF, B=0x01, cin=0, sub=0 -> 2 cycles later S=0x00, carry=1, ovf=0 (SAT build: S=0xFF).
- REQ-032 SHALL check: A=0x7F, B=0x01, cin=0, sub=0 -> S=0x80, carry=0, ovf=1; and A=0x05, B=0x07, sub=1, cin=1 -> S=0xFE, carry=0, ovf=0 (SAT build: S=0x00).
- REQ-033 SHALL check: 16 back-to-back random transfers with out_ready=1 -> 16 results in order, one per cycle, matching the reference model, in_ready constantly 1.
- REQ-034 SHALL check: out_ready=0 for 5 cycles during a stream -> in_ready=0 while out_valid=1, outputs frozen, no loss or duplication after release.
- REQ-035 SHALL check: rst_n pulsed low with 2 operations in flight -> out_valid=0, S=0 immediately; no stale result after release; a new transfer completes with correct latency.
- REQ-036 SHALL check: STAGES=1 and STAGES=4 (N=8) -> latency 1 and 4 cycles respectively; exhaustive 8-bit add/sub results are correct.

Source files
------------

// File: rtl/pipelined_adder.sv
// Segmented ripple adder/subtractor: STAGES carry-chain segments, one per pipeline stage, valid/ready flow.
// Define PIPELINED_ADDER_SAT_EN to saturate S (unsigned); carry and ovf always report raw values.
module pipelined_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         carry,
  output logic         ovf
);
  localparam int W = N / STAGES;

  logic                     en;
  logic [STAGES:1]          vld_q, c_q, sub_q, c_d;
  logic [STAGES:1][N-1:0]   a_q, b_q, s_q, s_d;
  logic [STAGES:0]          vld_pipe, c_p, sub_p;
  logic [STAGES:0][N-1:0]   a_p, b_p, s_p;
  logic [N-1:0]             s_raw;

  assign en        = !vld_q[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];

  // Index 0 is the incoming operand; B is inverted and the carry forced to 1 once, at entry.
  assign vld_pipe = {vld_q, in_valid};
  assign a_p      = {a_q, A};
  assign b_p      = {b_q, sub ? ~B : B};
  assign c_p      = {c_q, sub | cin};
  assign sub_p    = {sub_q, sub};
  assign s_p      = {s_q, {N{1'b0}}};

  always_comb begin
    logic [W:0] seg;
    seg = '0;
    c_d = '0;
    s_d = '0;
    for (int k = 1; k <= STAGES; k++) begin
      seg = {1'b0, a_p[k-1][(k-1)*W +: W]} + {1'b0, b_p[k-1][(k-1)*W +: W]}
          + {{W{1'b0}}, c_p[k-1]};
      s_d[k] = s_p[k-1];
      s_d[k][(k-1)*W +: W] = seg[W-1:0];
      c_d[k] = seg[W];
    end
  end

  // Data registers only load behind a valid op, so S/carry/ovf hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      sub_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
    end else if (en) begin
      vld_q <= vld_pipe[STAGES-1:0];
      for (int k = 1; k <= STAGES; k++) begin
        if (vld_pipe[k-1]) begin
          a_q[k]   <= a_p[k-1];
          b_q[k]   <= b_p[k-1];
          s_q[k]   <= s_d[k];
          c_q[k]   <= c_d[k];
          sub_q[k] <= sub_p[k-1];
        end
      end
    end
  end

  assign s_raw = s_q[STAGES];
  assign carry = c_q[STAGES];
  assign ovf   = (a_q[STAGES][N-1] == b_q[STAGES][N-1]) && (s_raw[N-1] != a_q[STAGES][N-1]);

`ifdef PIPELINED_ADDER_SAT_EN
  always_comb begin
    S = s_raw;
    if (!sub_q[STAGES] && carry)     S = '1;
    else if (sub_q[STAGES] && !carry) S = '0;
  end
`else
  assign S = s_raw;
`endif

  // Final-stage copies of the pass-through fields have no consumer.
  logic unused_ok;
  assign unused_ok = ^{a_p[STAGES], b_p[STAGES], c_p[STAGES], sub_p[STAGES],
                       s_p[STAGES], vld_pipe[STAGES]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: N=8 with STAGES=2 (main), 1 and 4, driven by shared stimulus.
module tb_pipelined_adder;
`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [2:0] irdy, ov, co, vo;
  logic [2:0][7:0] s_o;
  int n_chk = 0, n_err = 0, stall_waits = 0;

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic ci, logic sb);
    logic [7:0] bb, s;
    logic [8:0] r;
    logic       v;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {8'd0, sb ? 1'b1 : ci};
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    s  = r[7:0];
    if (SAT && !sb && r[8]) s = 8'hFF;
    if (SAT && sb && !r[8]) s = 8'h00;
    return {r[8], v, s};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [9:0] exp_q[$];
    logic [9:0] e;
    int pops = 0;

    pipelined_adder #(.N(8), .STAGES(ST)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[g]),
      .A(A), .B(B), .cin(cin), .sub(sub),
      .out_valid(ov[g]), .out_ready(out_ready),
      .S(s_o[g]), .carry(co[g]), .ovf(vo[g])
    );

    // Scoreboard: record accepted ops, compare each consumed result in order.
    always @(negedge clk) begin
      if (!rst_n) exp_q.delete();
      else begin
        chk($sformatf("in_ready_st%0d", ST), {31'd0, irdy[g]}, {31'd0, !ov[g] || out_ready});
        if (ov[g] && out_ready) begin
          pops++;
          if (exp_q.size() == 0) chk($sformatf("spurious_st%0d", ST), 1, 0);
          else begin
            e = exp_q.pop_front();
            chk($sformatf("result_st%0d", ST), {22'd0, co[g], vo[g], s_o[g]}, {22'd0, e});
          end
        end
        if (in_valid && irdy[g]) exp_q.push_back(model(A, B, cin, sub));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the op is accepted by the main DUT.
  task automatic send(logic [7:0] a, logic [7:0] b, logic ci, logic sb);
    int n = 0;
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!irdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    stall_waits += n;
    if (n >= 50) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Single op into an empty pipe: checks latency of all three depths and the main result.
  task automatic one_op(string tag, logic [7:0] a, logic [7:0] b, logic ci, logic sb,
                        logic ec, logic eo, logic [7:0] es_wrap, logic [7:0] es_sat);
    logic [9:0] exp;
    exp = {ec, eo, SAT ? es_sat : es_wrap};
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk({tag, "_lat1"}, {31'd0, ov[1]}, {31'd0, c == 1});
      chk({tag, "_lat2"}, {31'd0, ov[0]}, {31'd0, c == 2});
      chk({tag, "_lat4"}, {31'd0, ov[2]}, {31'd0, c == 4});
      if (c == 2) chk({tag, "_res"}, {22'd0, co[0], vo[0], s_o[0]}, {22'd0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ov"},   {29'd0, ov},   0);
    chk({tag, "_S"},    {24'd0, s_o[0]}, 0);
    chk({tag, "_c"},    {31'd0, co[0]}, 0);
    chk({tag, "_ovf"},  {31'd0, vo[0]}, 0);
    chk({tag, "_irdy"}, {29'd0, irdy}, 32'h7);
  endtask

  initial begin
    logic [9:0] hold;
    int p0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed vectors: tag, A, B, cin, sub, carry, ovf, S(wrap), S(sat)
    one_op("ff_p_01",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    one_op("7f_p_01",  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80);
    one_op("05_m_07",  8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00);
    one_op("80_m_01",  8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h7F);
    one_op("0f_p_f0c", 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
    one_op("3c_m_3c",  8'h3C, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    one_op("12_p_34c", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 8'h47, 8'h47);
    one_op("10_m_01",  8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h0F);
    one_op("80_p_80",  8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);

    // Back-to-back random stream with out_ready held high.
    stall_waits = 0;
    p0 = g_dut[0].pops;
    for (int i = 0; i < 16; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    chk("stream_stalls", stall_waits, 0);
    repeat (6) @(negedge clk);
    chk("stream_count", g_dut[0].pops - p0, 16);

    // Backpressure: consumer stalls while a stream is pending.
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 8; i++)
        send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = {co[0], vo[0], s_o[0]};
        repeat (4) begin
          @(negedge clk);
          chk("stall_ov",   {31'd0, ov[0]}, 1);
          chk("stall_irdy", {31'd0, irdy[0]}, 0);
          chk("stall_hold", {22'd0, co[0], vo[0], s_o[0]}, {22'd0, hold});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      case (g)
        0: chk("drain_st2", g_dut[0].exp_q.size(), 0);
        1: chk("drain_st1", g_dut[1].exp_q.size(), 0);
        default: chk("drain_st4", g_dut[2].exp_q.size(), 0);
      endcase
    end

    // Reset with two ops in flight.
    @(posedge clk);
    #1;
    send(8'h21, 8'h43, 1'b0, 1'b0);
    send(8'h99, 8'h11, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    one_op("post_rst", 8'hC8, 8'h64, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2C, 8'hFF);

    // Sweep of every A value in both modes through all three depths.
    for (int a = 0; a < 256; a++)
      for (int m = 0; m < 2; m++)
        send(8'(a), 8'(a * 73 + 29 + m * 101), a[0], m[0]);
    repeat (8) @(negedge clk);
    chk("sweep_drain_st1", g_dut[1].exp_q.size(), 0);
    chk("sweep_drain_st2", g_dut[0].exp_q.size(), 0);
    chk("sweep_drain_st4", g_dut[2].exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
